// File: rtl/bcd_scan_display.sv
// bcd_scan_display
//   Latches NDIG BCD nibbles from the bottle controller and drives a single
//   multiplexed 7-segment display by time-division scanning. New data is
//   staged and only copied to the displayed register at a frame boundary,
//   so a frame never mixes two loads. Supports leading-zero blanking and a
//   whole-display blink.
//
// Ports
//   CLK         system clock, all state on rising edge
//   RST_n       asynchronous active-low reset
//   load        1-cycle strobe, samples digits_in into the staging register
//   digits_in   BCD nibbles, digit k (1 = LSD) at [4k-1:4k-4]
//   blank_lz    1 = blank leading zeros (digit 1 is never blanked)
//   blink_en    1 = blink the whole display
//   seg         {a,b,c,d,e,f,g}, inverted when SEG_ACT_LO = 1
//   dig_sel     one-hot digit enable, bit k-1 selects digit k
//   frame_done  1 during the last cycle of the last slot of a frame
module bcd_scan_display #(
  parameter int unsigned NDIG       = 5,
  parameter int unsigned PRESC      = 1000,
  parameter int unsigned BLINK_DIV  = 64,
  parameter bit          SEG_ACT_LO = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              load,
  input  logic [4*NDIG-1:0] digits_in,
  input  logic              blank_lz,
  input  logic              blink_en,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   dig_sel,
  output logic              frame_done
);

  localparam int unsigned PW = (PRESC > 1)     ? $clog2(PRESC)     : 1;
  localparam int unsigned SW = (NDIG > 1)      ? $clog2(NDIG)      : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0]     presc_cnt;
  logic [SW-1:0]     slot;
  logic [4*NDIG-1:0] staging;
  logic [4*NDIG-1:0] disp;
  logic              pending;
  logic [BW-1:0]     blink_cnt;
  logic              phase;
  logic [6:0]        seg_r;

  logic              presc_wrap;
  logic              frame_end;
  logic [3:0]        cur_nib;
  logic              lead_zero;
  logic              zero_run;
  logic [NDIG-1:0]   sel_oh;
  logic [6:0]        seg_next;

  assign presc_wrap = (presc_cnt == PW'(PRESC - 1));
  assign frame_end  = presc_wrap && (slot == SW'(NDIG - 1));
  assign frame_done = frame_end;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = 7'b0000001;
    endcase
  endfunction

  // Slot timing
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      presc_cnt <= '0;
      slot      <= '0;
    end else if (presc_wrap) begin
      presc_cnt <= '0;
      slot      <= (slot == SW'(NDIG - 1)) ? '0 : slot + 1'b1;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  // Staging/display transfer. A load in the boundary cycle still lets disp
  // take the old staging value; the new value stays pending for one frame.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      staging <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else begin
      if (frame_end && pending)
        disp <= staging;
      if (load) begin
        staging <= digits_in;
        pending <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

  // Blink phase, counted in frames; held clear while blinking is off so
  // enabling it always starts with a visible half-period.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (!blink_en) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Walk from the MSD down: zero_run stays set while every digit at or
  // above the current one is zero.
  always_comb begin
    cur_nib   = '0;
    lead_zero = 1'b0;
    zero_run  = 1'b1;
    sel_oh    = '0;
    for (int unsigned i = NDIG; i > 0; i--) begin
      zero_run = zero_run && (disp[4*(i-1) +: 4] == 4'd0);
      if (SW'(i - 1) == slot) begin
        cur_nib    = disp[4*(i-1) +: 4];
        lead_zero  = zero_run && (i > 1);
        sel_oh[i-1] = 1'b1;
      end
    end
  end

  always_comb begin
    seg_next = decode(cur_nib);
    if ((blank_lz && lead_zero) || (blink_en && phase))
      seg_next = '0;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      seg_r   <= '0;
      dig_sel <= '0;
    end else begin
      seg_r   <= seg_next;
      dig_sel <= sel_oh;
    end
  end

  assign seg = seg_r ^ {7{SEG_ACT_LO}};

endmodule

// File: tb/tb_bcd_scan_display.sv
// Testbench for bcd_scan_display: directed scenarios followed by random
// loads/blank/blink activity, checked every cycle against a reference
// model based on cycle arithmetic and frame-level data hand-over.
module tb_bcd_scan_display;

  localparam int unsigned NDIG      = 5;
  localparam int unsigned PRESC     = 4;
  localparam int unsigned BLINK_DIV = 2;
  localparam int unsigned FRAME     = NDIG * PRESC;

  logic        CLK       = 1'b0;
  logic        RST_n     = 1'b0;
  logic        load      = 1'b0;
  logic [19:0] digits_in = '0;
  logic        blank_lz  = 1'b0;
  logic        blink_en  = 1'b0;
  logic [6:0]  seg;
  logic [4:0]  dig_sel;
  logic        frame_done;

  bcd_scan_display #(
    .NDIG(NDIG),
    .PRESC(PRESC),
    .BLINK_DIV(BLINK_DIV),
    .SEG_ACT_LO(1'b0)
  ) dut (
    .CLK(CLK),
    .RST_n(RST_n),
    .load(load),
    .digits_in(digits_in),
    .blank_lz(blank_lz),
    .blink_en(blink_en),
    .seg(seg),
    .dig_sel(dig_sel),
    .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [6:0]  seg_tab [16];

  // Reference model state
  int unsigned k;        // rising edges since reset release
  logic [19:0] staged;
  logic [19:0] shown;
  bit          pending;
  int unsigned nb;       // frame boundaries since blink was enabled
  logic [6:0]  exp_seg;
  logic [4:0]  exp_dig;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t, k=%0d)", tag, got, want, $time, k);
    end
  endtask

  task automatic model_reset();
    k       = 0;
    staged  = '0;
    shown   = '0;
    pending = 1'b0;
    nb      = 0;
    exp_seg = '0;
    exp_dig = '0;
  endtask

  // Called at a falling edge: checks the outputs, drives this cycle's
  // inputs, predicts the outputs after the next rising edge.
  task automatic tick(input bit ld, input logic [19:0] d);
    int unsigned s;
    bit          fd;
    logic [19:0] upper;
    bit          lead;
    bit          dark;
    check("seg", 32'(seg), 32'(exp_seg));
    check("dig_sel", 32'(dig_sel), 32'(exp_dig));
    check("frame_done", 32'(frame_done), 32'((k % FRAME) == FRAME - 1));
    load      = ld;
    digits_in = d;
    s     = (k / PRESC) % NDIG;
    fd    = ((k % FRAME) == FRAME - 1);
    upper = shown >> (4 * s);
    lead  = blank_lz && (s > 0) && (upper == 20'd0);
    dark  = blink_en && (((nb / BLINK_DIV) % 2) == 1);
    exp_seg = (lead || dark) ? 7'd0 : seg_tab[upper[3:0]];
    exp_dig = 5'(1 << s);
    if (fd && pending) begin
      shown   = staged;
      pending = 1'b0;
    end
    if (ld) begin
      staged  = d;
      pending = 1'b1;
    end
    nb = blink_en ? nb + (fd ? 1 : 0) : 0;
    k++;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  function automatic logic [19:0] rand_digits();
    logic [19:0] v;
    logic [3:0]  n;
    int unsigned lz;
    v  = '0;
    lz = $urandom_range(0, 5);
    for (int i = 0; i < 5; i++) begin
      n = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      if (i >= 5 - lz) n = 4'd0;
      v[4*i +: 4] = n;
    end
    return v;
  endfunction

  task automatic mid_reset();
    load = 1'b0;
    #2 RST_n = 1'b0;
    #1;
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_dig_sel", 32'(dig_sel), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    model_reset();
    RST_n = 1'b1;
  endtask

  task automatic random_run(input int unsigned cycles);
    for (int unsigned c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 39) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 59) == 0) blink_en = ~blink_en;
      tick($urandom_range(0, 5) == 0, rand_digits());
    end
  endtask

  initial begin
    seg_tab[0]  = 7'b1111110; seg_tab[1]  = 7'b0110000;
    seg_tab[2]  = 7'b1101101; seg_tab[3]  = 7'b1111001;
    seg_tab[4]  = 7'b0110011; seg_tab[5]  = 7'b1011011;
    seg_tab[6]  = 7'b1011111; seg_tab[7]  = 7'b1110000;
    seg_tab[8]  = 7'b1111111; seg_tab[9]  = 7'b1111011;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0000001;

    model_reset();
    repeat (3) @(negedge CLK);
    check("por_seg", 32'(seg), 32'd0);
    check("por_dig_sel", 32'(dig_sel), 32'd0);
    check("por_frame_done", 32'(frame_done), 32'd0);
    RST_n = 1'b1;

    // Digits 0,0,1,2,3 (MSD..LSD), no blanking
    tick(1'b1, 20'h00123);
    repeat (2 * FRAME + 3) tick(1'b0, '0);

    // Same data blanked, then all-zero data
    blank_lz = 1'b1;
    repeat (FRAME) tick(1'b0, '0);
    tick(1'b1, 20'h00000);
    repeat (2 * FRAME) tick(1'b0, '0);
    blank_lz = 1'b0;

    // Two loads within one frame: the last one wins
    tick(1'b1, 20'h11111);
    repeat (3) tick(1'b0, '0);
    tick(1'b1, 20'h22222);
    repeat (2 * FRAME) tick(1'b0, '0);

    // Load in the boundary cycle lands one frame later
    tick(1'b1, 20'h45678);
    while ((k % FRAME) != FRAME - 1) tick(1'b0, '0);
    tick(1'b1, 20'h98765);
    repeat (2 * FRAME + 2) tick(1'b0, '0);

    // Blink for several periods, then drop it mid-frame
    blink_en = 1'b1;
    repeat (6 * FRAME + 7) tick(1'b0, '0);
    blink_en = 1'b0;
    repeat (FRAME) tick(1'b0, '0);

    // Non-BCD nibble shows a dash
    tick(1'b1, 20'h000C0);
    repeat (2 * FRAME) tick(1'b0, '0);

    random_run(500);
    mid_reset();
    random_run(500);
    mid_reset();
    blink_en = 1'b1;
    random_run(300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
